gcd_sequencer: RTL
==================

# gcd_sequencer

Moore-style control unit that sequences the subtract-and-compare GCD datapath of the Processor. It captures two operands through the `Enter` strobe and drives the A/B register load and select lines. It steers the loop from the datapath's comparator flags and raises `Halt` once the result register holds GCD(A,B). The datapath registers, the subtractor and the output register live outside this block; this block contains only the sequencing logic.

## Interface
- `WIDTH`, 8 — operand width (sizes the step counter limit check only).
- `MAX_STEPS`, 255 — subtraction count after which the run is aborted.
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low.
- `Enter` in 1 — operand-entry strobe, level; only rising edges act.
- `AeqB`, `AgtB`, `Azero`, `Bzero` in 1 each — datapath flags, combinational from registered A/B.
- `ALoad`, `BLoad` out 1 — register load enables.
- `ASel`, `BSel` out 1 — 0 = load `Minput`, 1 = load difference (A−B / B−A).
- `OutLoad` out 1 — result register load.
- `OutSel` out 1 — 0 = result from A, 1 = result from B.
- `Halt` out 1 — result valid.
- `Fault` out 1 — watchdog abort.
- `Steps` out 16 — subtractions performed in the current run.
- `DisplayState` out 4 — current state code.

## Operation
- `rise = Enter & ~enter_q`; `enter_q` is a registered copy of `Enter`.
- States, with their `DisplayState` codes:
  - 0 IDLE: wait for `rise`, then go to LOADA.
  - 1 LOADA: `ALoad=1`, `ASel=0`; go to WAITB.
  - 2 WAITB: wait for `rise`, then go to LOADB.
  - 3 LOADB: `BLoad=1`, `BSel=0`; go to CHECK.
  - 4 CHECK, priority order:
    - `AeqB` → DONE with OutSel=0;
    - else `Bzero` → DONE with OutSel=0;
    - else `Azero` → DONE with OutSel=1;
    - else step limit reached → FAULT;
    - else `AgtB` → SUBA;
    - else → SUBB.
  - 5 SUBA: `ALoad=1`, `ASel=1`, `Steps`+1; go to CHECK.
  - 6 SUBB: `BLoad=1`, `BSel=1`, `Steps`+1; go to CHECK.
  - 7 DONE: `OutLoad=1` with the latched `OutSel`; go to HALT.
  - 8 HALT: `Halt=1`; on `rise`, clear `Steps` and go to LOADA (a new run begins).
  - 9 FAULT: `Fault=1`; on `rise`, clear `Steps` and go to LOADA.
- `OutSel` is registered, set in CHECK and held through DONE/HALT.
- Outputs are decoded from state only. The exception is `OutSel`, which is registered as stated above.
- All outputs not listed for a state are 0. Unused codes 10–15 → IDLE.
- `Enter` edges in LOADA, LOADB, CHECK, SUBA, SUBB and DONE are ignored; `enter_q` still tracks `Enter`.
- Zero operands: gcd(x,0)=x, gcd(0,y)=y, gcd(0,0)=0 (via `AeqB`). No state loops forever on zero.
- Step limit check: `Steps >= MAX_STEPS`, evaluated in CHECK before any subtraction.

## Timing
- Reset values:
  - state IDLE;
  - `enter_q`=1, so an `Enter` held through reset release does not fire;
  - `Steps`=0, `OutSel`=0;
  - all control outputs 0, `DisplayState`=0.
- `rise` sampled in cycle n → LOADA in cycle n+1. The load takes effect at the n+2 edge.
- Second `rise` in cycle m → LOADB at m+1 → CHECK at m+2.
- Each loop iteration is 2 cycles (CHECK + SUB).
- `Halt` rises 2 cycles after a terminating CHECK cycle and stays high until the next `rise`.
- `Enter` held high for k≥1 cycles produces exactly one `rise`.
- Reset asserted in any state returns to IDLE immediately, asynchronously. All outputs take reset values.

## Configuration
- `GCD_SEQ_STEPCOUNT_EN` defined: the `Steps` counter, the watchdog check and the FAULT state are built.
- Undefined:
  - `Steps` tied 0 and `Fault` tied 0;
  - the CHECK watchdog branch and state 9 are removed (code 9 falls to IDLE);
  - all other behaviour is unchanged.

## Test plan
- Reset, enter A=12, B=18 with a behavioural datapath:
  - states 4,6,4,5,4,7,8;
  - `Halt`=1, result 6, `Steps`=2.
- A=7, B=0 → `OutSel`=0, result 7, `Steps`=0. A=0, B=9 → `OutSel`=1, result 9. A=0, B=0 → result 0.
- `MAX_STEPS`=4, A=13, B=1 → `Fault`=1 after 4 subtractions, `Halt`=0, `DisplayState`=9.
- `Enter` held 5 cycles at entry of A, plus an extra pulse during SUBA → exactly one LOADA, and the loop is unaffected.
- Reset pulsed mid-loop (state 5) → `DisplayState`=0 and all outputs 0 at once. A fresh run with 100/75 then gives 25.
- 100 random 1..127 operand pairs, each compared against a software subtractive GCD, back-to-back runs via `rise` in HALT → 0 mismatches.

Source files
------------

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: Moore control unit for the subtract-and-compare GCD datapath.
// Macro GCD_SEQ_STEPCOUNT_EN builds the step counter, watchdog check and FAULT state.
module gcd_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Enter,
  input  logic        AeqB,
  input  logic        AgtB,
  input  logic        Azero,
  input  logic        Bzero,
  output logic        ALoad,
  output logic        BLoad,
  output logic        ASel,
  output logic        BSel,
  output logic        OutLoad,
  output logic        OutSel,
  output logic        Halt,
  output logic        Fault,
  output logic [15:0] Steps,
  output logic [3:0]  DisplayState
);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOADA = 4'd1,
    WAITB = 4'd2,
    LOADB = 4'd3,
    CHECK = 4'd4,
    SUBA  = 4'd5,
    SUBB  = 4'd6,
    DONE  = 4'd7,
    HALT  = 4'd8,
    FAULT = 4'd9
  } state_t;

  localparam int unsigned CAP = (1 << WIDTH) - 1;
  localparam logic [15:0] LIMIT = 16'((MAX_STEPS < CAP) ? MAX_STEPS : CAP);

  state_t      state_q, state_d;
  logic        enter_q, rise, out_sel_d;

  assign rise = Enter & ~enter_q;

`ifdef GCD_SEQ_STEPCOUNT_EN
  logic [15:0] steps_q, steps_d;
  assign Steps = steps_q;
  // Count each subtraction; a new run started from HALT/FAULT starts from zero.
  always_comb
    steps_d = (state_q == SUBA || state_q == SUBB) ? steps_q + 16'd1 :
              (rise && (state_q == HALT || state_q == FAULT)) ? '0 : steps_q;
  // Step counter register.
  always_ff @(posedge clock or negedge reset)
    if (!reset) steps_q <= '0;
    else        steps_q <= steps_d;
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign Steps = '0;
  assign Fault = 1'b0;
`endif

  // Next state; OutSel is decided only when CHECK terminates the loop.
  always_comb begin
    state_d   = state_q;
    out_sel_d = OutSel;
    case (state_q)
      IDLE:  state_d = rise ? LOADA : IDLE;
      LOADA: state_d = WAITB;
      WAITB: state_d = rise ? LOADB : WAITB;
      LOADB: state_d = CHECK;
      CHECK: begin
        if (AeqB || Bzero || Azero) begin
          state_d   = DONE;
          out_sel_d = ~AeqB & ~Bzero;
        end
`ifdef GCD_SEQ_STEPCOUNT_EN
        else if (steps_q >= LIMIT) state_d = FAULT;
`endif
        else state_d = AgtB ? SUBA : SUBB;
      end
      SUBA, SUBB: state_d = CHECK;
      DONE:  state_d = HALT;
      HALT:  state_d = rise ? LOADA : HALT;
`ifdef GCD_SEQ_STEPCOUNT_EN
      FAULT: state_d = rise ? LOADA : FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, edge detector and outputs registered from the next state so they track the state code.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q      <= IDLE;
      enter_q      <= 1'b1;
      OutSel       <= 1'b0;
      ALoad        <= 1'b0;
      BLoad        <= 1'b0;
      ASel         <= 1'b0;
      BSel         <= 1'b0;
      OutLoad      <= 1'b0;
      Halt         <= 1'b0;
`ifdef GCD_SEQ_STEPCOUNT_EN
      Fault        <= 1'b0;
`endif
      DisplayState <= 4'd0;
    end else begin
      state_q      <= state_d;
      enter_q      <= Enter;
      OutSel       <= out_sel_d;
      ALoad        <= state_d == LOADA || state_d == SUBA;
      BLoad        <= state_d == LOADB || state_d == SUBB;
      ASel         <= state_d == SUBA;
      BSel         <= state_d == SUBB;
      OutLoad      <= state_d == DONE;
      Halt         <= state_d == HALT;
`ifdef GCD_SEQ_STEPCOUNT_EN
      Fault        <= state_d == FAULT;
`endif
      DisplayState <= state_d;
    end
endmodule
